// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - program memory fetch handshake between sequencer and memory
interface instruction_sequencer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/decode/execute/commit phase sequencer owning PC and IR
module instruction_sequencer #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  instruction_sequencer_if.master mem,
  output logic [15:0]           o_instruction,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_fetch,
  output logic                  o_decode,
  output logic                  o_execute,
  output logic                  o_commit,
  input  logic                  i_exec_wait,
  input  logic                  i_pc_load,
  input  logic [ADDR_WIDTH-1:0] i_pc_load_value,
  input  logic                  i_halt,
  input  logic                  i_run,
  output logic                  o_halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_COMMIT,
    S_HALTED
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [15:0]           r_instruction;
  logic                  w_fetch_done;

  assign w_fetch_done = (r_state == S_FETCH) && mem.mem_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_VECTOR;
      r_instruction <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (w_fetch_done) begin
        r_instruction <= mem.mem_rdata;
      end
      // PC moves only at commit; a jump target overrides the sequential increment
      if (r_state == S_COMMIT) begin
        r_pc <= i_pc_load ? i_pc_load_value : (r_pc + PC_ONE);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    w_next_state = S_FETCH;
      S_FETCH:   w_next_state = mem.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  w_next_state = S_EXECUTE;
      S_EXECUTE: w_next_state = i_exec_wait ? S_EXECUTE : S_COMMIT;
      S_COMMIT:  w_next_state = i_halt ? S_HALTED : S_FETCH;
      S_HALTED:  w_next_state = i_run ? S_FETCH : S_HALTED;
      default:   w_next_state = S_IDLE;
    endcase
  end

  assign mem.mem_req   = (r_state == S_FETCH);
  assign mem.mem_addr  = r_pc;
  assign o_fetch       = (r_state == S_FETCH);
  assign o_decode      = (r_state == S_DECODE);
  assign o_execute     = (r_state == S_EXECUTE);
  assign o_commit      = (r_state == S_COMMIT);
  assign o_halted      = (r_state == S_HALTED);
  assign o_pc          = r_pc;
  assign o_instruction = r_instruction;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - instruction-level checks of the sequencer against a PC/IR model
module tb_instruction_sequencer;

  localparam logic [5:0] P_NONE  = 6'b000000;
  localparam logic [5:0] P_FETCH = 6'b100001;
  localparam logic [5:0] P_DEC   = 6'b010000;
  localparam logic [5:0] P_EXE   = 6'b001000;
  localparam logic [5:0] P_COM   = 6'b000100;
  localparam logic [5:0] P_HALT  = 6'b000010;

  typedef struct {
    int          fetch_delay;
    int          exec_waits;
    bit          load;
    logic [15:0] load_value;
    bit          halt;
    int          halt_cycles;
    logic [15:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] o_instruction;
  logic [15:0] o_pc;
  logic        o_fetch, o_decode, o_execute, o_commit, o_halted;
  logic        i_exec_wait, i_pc_load, i_halt, i_run;
  logic [15:0] i_pc_load_value;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_pc;
  logic [15:0] m_instr;

  instruction_sequencer_if #(.ADDR_WIDTH(16)) bus ();

  instruction_sequencer #(.ADDR_WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .mem             (bus),
    .o_instruction   (o_instruction),
    .o_pc            (o_pc),
    .o_fetch         (o_fetch),
    .o_decode        (o_decode),
    .o_execute       (o_execute),
    .o_commit        (o_commit),
    .i_exec_wait     (i_exec_wait),
    .i_pc_load       (i_pc_load),
    .i_pc_load_value (i_pc_load_value),
    .i_halt          (i_halt),
    .i_run           (i_run),
    .o_halted        (o_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] phase();
    return {o_fetch, o_decode, o_execute, o_commit, o_halted, bus.mem_req};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One whole instruction, entered with the sequencer in FETCH and left in FETCH
  task automatic run_instr(input vec_t v);
    chk("fetch_phase", {26'd0, phase()}, {26'd0, P_FETCH});
    chk("fetch_addr", {16'd0, bus.mem_addr}, {16'd0, m_pc});
    chk("pc_at_fetch", {16'd0, o_pc}, {16'd0, m_pc});
    for (int k = 0; k <= v.fetch_delay; k++) begin
      bus.mem_ready = (k == v.fetch_delay);
      bus.mem_rdata = (k == v.fetch_delay) ? v.word : 16'($urandom);
      tick();
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = 16'($urandom);
      if (k < v.fetch_delay) begin
        chk("wait_fetch_phase", {26'd0, phase()}, {26'd0, P_FETCH});
        chk("wait_instr_held", {16'd0, o_instruction}, {16'd0, m_instr});
      end
    end
    m_instr = v.word;
    chk("decode_phase", {26'd0, phase()}, {26'd0, P_DEC});
    chk("decode_instr", {16'd0, o_instruction}, {16'd0, m_instr});
    i_pc_load       = 1'b1;
    i_pc_load_value = 16'($urandom);
    i_halt          = 1'($urandom_range(0, 1));
    i_exec_wait     = 1'($urandom_range(0, 1));
    tick();
    chk("execute_phase", {26'd0, phase()}, {26'd0, P_EXE});
    i_pc_load = 1'b0;
    i_halt    = 1'b0;
    for (int w = 0; w < v.exec_waits; w++) begin
      i_exec_wait = 1'b1;
      tick();
      chk("exec_stall_phase", {26'd0, phase()}, {26'd0, P_EXE});
    end
    i_exec_wait = 1'b0;
    tick();
    chk("commit_phase", {26'd0, phase()}, {26'd0, P_COM});
    chk("commit_pc_old", {16'd0, o_pc}, {16'd0, m_pc});
    chk("commit_instr", {16'd0, o_instruction}, {16'd0, m_instr});
    i_pc_load       = v.load;
    i_pc_load_value = v.load_value;
    i_halt          = v.halt;
    i_run           = 1'($urandom_range(0, 1));
    tick();
    m_pc = v.load ? v.load_value : m_pc + 16'd1;
    i_pc_load   = 1'b0;
    i_halt      = 1'b0;
    i_run       = 1'b0;
    i_exec_wait = 1'($urandom_range(0, 1));
    if (v.halt) begin
      for (int h = 0; h < v.halt_cycles; h++) begin
        chk("halted_phase", {26'd0, phase()}, {26'd0, P_HALT});
        chk("halted_pc", {16'd0, o_pc}, {16'd0, m_pc});
        chk("halted_instr", {16'd0, o_instruction}, {16'd0, m_instr});
        i_halt        = 1'($urandom_range(0, 1));
        bus.mem_ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("halted_before_run", {26'd0, phase()}, {26'd0, P_HALT});
      i_run  = 1'b1;
      i_halt = 1'b1;
      tick();
      i_run  = 1'b0;
      i_halt = 1'b0;
    end
  endtask

  vec_t vecs[7];

  initial begin
    rst             = 1'b1;
    i_exec_wait     = 1'b0;
    i_pc_load       = 1'b0;
    i_pc_load_value = 16'h0000;
    i_halt          = 1'b0;
    i_run           = 1'b0;
    bus.mem_ready   = 1'b1;
    bus.mem_rdata   = 16'hDEAD;

    vecs[0] = '{0, 0, 1'b0, 16'h0000, 1'b0, 0,  16'hC512};
    vecs[1] = '{3, 0, 1'b0, 16'h0000, 1'b0, 0,  16'hA001};
    vecs[2] = '{0, 2, 1'b0, 16'h0000, 1'b0, 0,  16'h3003};
    vecs[3] = '{0, 0, 1'b1, 16'h1234, 1'b0, 0,  16'h4004};
    vecs[4] = '{1, 0, 1'b1, 16'hFFFF, 1'b0, 0,  16'h5005};
    vecs[5] = '{0, 0, 1'b0, 16'h0000, 1'b0, 0,  16'h6006};
    vecs[6] = '{0, 1, 1'b1, 16'h0080, 1'b1, 10, 16'h7007};

    tick();
    tick();
    chk("reset_phase", {26'd0, phase()}, {26'd0, P_NONE});
    chk("reset_pc", {16'd0, o_pc}, 32'h0);
    chk("reset_instr", {16'd0, o_instruction}, 32'h0);
    m_pc    = 16'h0000;
    m_instr = 16'h0000;

    rst = 1'b0;
    chk("idle_phase", {26'd0, phase()}, {26'd0, P_NONE});
    tick();

    foreach (vecs[i]) run_instr(vecs[i]);

    for (int n = 0; n < 60; n++) begin
      vec_t r;
      r.fetch_delay = $urandom_range(0, 3);
      r.exec_waits  = $urandom_range(0, 3);
      r.load        = ($urandom_range(0, 3) == 0);
      r.load_value  = 16'($urandom);
      r.halt        = ($urandom_range(0, 5) == 0);
      r.halt_cycles = $urandom_range(1, 3);
      r.word        = 16'($urandom);
      run_instr(r);
    end

    // Reset while stalled in EXECUTE abandons the instruction
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick();
    chk("rst_seq_decode", {26'd0, phase()}, {26'd0, P_DEC});
    i_exec_wait = 1'b1;
    tick();
    tick();
    chk("rst_seq_execute", {26'd0, phase()}, {26'd0, P_EXE});
    rst = 1'b1;
    tick();
    chk("midexec_rst_phase", {26'd0, phase()}, {26'd0, P_NONE});
    chk("midexec_rst_pc", {16'd0, o_pc}, 32'h0);
    chk("midexec_rst_instr", {16'd0, o_instruction}, 32'h0);
    chk("midexec_rst_addr", {16'd0, bus.mem_addr}, 32'h0);
    rst         = 1'b0;
    i_exec_wait = 1'b0;
    m_pc        = 16'h0000;
    m_instr     = 16'h0000;
    tick();
    run_instr('{0, 0, 1'b0, 16'h0000, 1'b0, 0, 16'h1111});
    chk("post_rst_fetch_addr", {16'd0, bus.mem_addr}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
